// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst memory slave: independent write/read FSMs, one outstanding burst per direction.
// FIXED/INCR bursts of 32-bit words; WRAP, reserved bursts and non-word sizes answer SLVERR.
module axi4_burst_slave_mem #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  // AW channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic [2:0]                      AWSIZE,
  input  logic [1:0]                      AWBURST,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  // W channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  // B channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     BID,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  // AR channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                      ARLEN,
  input  logic [2:0]                      ARSIZE,
  input  logic [1:0]                      ARBURST,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  // R channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RLAST,
  output logic                            RVALID,
  input  logic                            RREADY
);

  localparam int unsigned WordAw = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned Depth  = 1 << WordAw;
  localparam int unsigned StrbW  = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [2:0] SizeWord   = 3'b010;

  typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
  typedef enum logic       {RdIdle, RdData}         rd_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [Depth];

  // FIXED holds the word address; everything else that is legal steps and wraps modulo Depth.
  function automatic logic [WordAw-1:0] next_addr(input logic [WordAw-1:0] a,
                                                  input logic [1:0]        burst);
    return (burst == BurstFixed) ? a : a + WordAw'(1);
  endfunction

  function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size != SizeWord);
  endfunction

  // ---------------------------------------------------------------- write path
  wr_state_e                   wr_state_q;
  logic                        awready_q, wready_q, bvalid_q;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_q;
  logic [1:0]                  bresp_q;
  logic [WordAw-1:0]           wr_addr_q;
  logic [7:0]                  wr_len_q, wr_beat_q;
  logic [1:0]                  wr_burst_q;
  logic                        wr_bad_q, wr_last_err_q;
  logic                        wr_fire, wr_is_last, wr_last_bad;

  assign wr_fire     = wready_q & WVALID;
  assign wr_is_last  = (wr_beat_q == wr_len_q);
  assign wr_last_bad = (WLAST != wr_is_last);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q    <= WrIdle;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bid_q         <= '0;
      bresp_q       <= RespOkay;
      wr_addr_q     <= '0;
      wr_len_q      <= '0;
      wr_beat_q     <= '0;
      wr_burst_q    <= BurstFixed;
      wr_bad_q      <= 1'b0;
      wr_last_err_q <= 1'b0;
    end else begin
      unique case (wr_state_q)
        WrIdle: begin
          awready_q <= 1'b1;
          if (awready_q && AWVALID) begin
            awready_q     <= 1'b0;
            wready_q      <= 1'b1;
            bid_q         <= AWID;
            wr_addr_q     <= AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            wr_len_q      <= AWLEN;
            wr_burst_q    <= AWBURST;
            wr_beat_q     <= '0;
            wr_bad_q      <= bad_req(AWBURST, AWSIZE);
            wr_last_err_q <= 1'b0;
            wr_state_q    <= WrData;
          end
        end
        WrData: begin
          if (wr_fire) begin
            wr_beat_q <= wr_beat_q + 8'd1;
            wr_addr_q <= next_addr(wr_addr_q, wr_burst_q);
            if (wr_last_bad) wr_last_err_q <= 1'b1;
            // Burst length comes from AWLEN; a misplaced WLAST only poisons the response.
            if (wr_is_last) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= (wr_bad_q || wr_last_err_q || wr_last_bad) ? RespSlvErr : RespOkay;
              wr_state_q <= WrResp;
            end
          end
        end
        WrResp: begin
          if (BREADY) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= WrIdle;
          end
        end
        default: wr_state_q <= WrIdle;
      endcase
    end
  end

  // Storage is deliberately not reset so data survives an aborted burst.
  always_ff @(posedge ACLK) begin
    if (wr_fire && !wr_bad_q) begin
      for (int b = 0; b < StrbW; b++) begin
        if (WSTRB[b]) mem[wr_addr_q][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read path
  rd_state_e                     rd_state_q;
  logic                          arready_q, rvalid_q, rlast_q;
  logic [C_S_AXI_ID_WIDTH-1:0]   rid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    rresp_q;
  logic [WordAw-1:0]             rd_addr_q;
  logic [7:0]                    rd_len_q, rd_beat_q;
  logic [1:0]                    rd_burst_q;
  logic                          rd_bad_q;
  logic [WordAw-1:0]             ar_word;

  assign ar_word = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // rd_addr_q always points at the word to load for the beat after the one on RDATA.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_q <= RdIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_beat_q  <= '0;
      rd_burst_q <= BurstFixed;
      rd_bad_q   <= 1'b0;
    end else begin
      unique case (rd_state_q)
        RdIdle: begin
          arready_q <= 1'b1;
          if (arready_q && ARVALID) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rid_q      <= ARID;
            rd_len_q   <= ARLEN;
            rd_burst_q <= ARBURST;
            rd_beat_q  <= '0;
            rd_bad_q   <= bad_req(ARBURST, ARSIZE);
            rdata_q    <= bad_req(ARBURST, ARSIZE) ? '0 : mem[ar_word];
            rresp_q    <= bad_req(ARBURST, ARSIZE) ? RespSlvErr : RespOkay;
            rlast_q    <= (ARLEN == 8'd0);
            rd_addr_q  <= next_addr(ar_word, ARBURST);
            rd_state_q <= RdData;
          end
        end
        RdData: begin
          if (RREADY) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
              rd_state_q <= RdIdle;
            end else begin
              rd_beat_q <= rd_beat_q + 8'd1;
              rdata_q   <= rd_bad_q ? '0 : mem[rd_addr_q];
              rlast_q   <= ((rd_beat_q + 8'd1) == rd_len_q);
              rd_addr_q <= next_addr(rd_addr_q, rd_burst_q);
            end
          end
        end
        default: rd_state_q <= RdIdle;
      endcase
    end
  end

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Scoreboard bench for axi4_burst_slave_mem: drivers push expected B/R responses from a
// word-array memory model; negedge monitors pop and compare, and check stall stability.
module tb_axi4_burst_slave_mem;

  localparam int IdW     = 1;
  localparam int AddrW   = 8;
  localparam int Depth   = 64;
  localparam int Timeout = 200;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;

  logic [IdW-1:0]   AWID = '0;
  logic [AddrW-1:0] AWADDR = '0;
  logic [7:0]       AWLEN = '0;
  logic [2:0]       AWSIZE = '0;
  logic [1:0]       AWBURST = '0;
  logic             AWVALID = 1'b0;
  logic             AWREADY;
  logic [31:0]      WDATA = '0;
  logic [3:0]       WSTRB = '0;
  logic             WLAST = 1'b0;
  logic             WVALID = 1'b0;
  logic             WREADY;
  logic [IdW-1:0]   BID;
  logic [1:0]       BRESP;
  logic             BVALID;
  logic             BREADY = 1'b0;
  logic [IdW-1:0]   ARID = '0;
  logic [AddrW-1:0] ARADDR = '0;
  logic [7:0]       ARLEN = '0;
  logic [2:0]       ARSIZE = '0;
  logic [1:0]       ARBURST = '0;
  logic             ARVALID = 1'b0;
  logic             ARREADY;
  logic [IdW-1:0]   RID;
  logic [31:0]      RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;
  logic             RVALID;
  logic             RREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  axi4_burst_slave_mem #(
    .C_S_AXI_ID_WIDTH  (IdW),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AddrW)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .AWID   (AWID),
    .AWADDR (AWADDR),
    .AWLEN  (AWLEN),
    .AWSIZE (AWSIZE),
    .AWBURST(AWBURST),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WLAST  (WLAST),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BID    (BID),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARID   (ARID),
    .ARADDR (ARADDR),
    .ARLEN  (ARLEN),
    .ARSIZE (ARSIZE),
    .ARBURST(ARBURST),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RID    (RID),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RLAST  (RLAST),
    .RVALID (RVALID),
    .RREADY (RREADY)
  );

  typedef struct {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_exp_t;

  typedef struct {
    logic [IdW-1:0] id;
    logic [31:0]    data;
    logic [1:0]     resp;
    logic           last;
  } r_exp_t;

  int tests = 0;
  int fails = 0;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] model [Depth];
  logic [31:0] wdata [256];
  logic [3:0]  wstrb [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no handshake within %0d cycles, required one", name, Timeout);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // ------------------------------------------------------------------ monitors
  logic        b_stall = 1'b0;
  logic [2:0]  b_hold;
  logic        r_stall = 1'b0;
  logic [35:0] r_hold;

  always @(negedge ACLK) begin
    if (ARESET) begin
      b_stall = 1'b0;
    end else begin
      if (b_stall) check("b_stable", 64'({BVALID, BID, BRESP}), 64'({1'b1, b_hold}));
      if (BVALID && BREADY) begin
        if (bq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL b_unexpected: got BID=%h BRESP=%h, required no response", BID, BRESP);
        end else begin
          b_exp_t e;
          e = bq.pop_front();
          check("b_resp", 64'({BID, BRESP}), 64'({e.id, e.resp}));
        end
      end
      b_stall = BVALID && !BREADY;
      b_hold  = {BID, BRESP};
    end
  end

  always @(negedge ACLK) begin
    if (ARESET) begin
      r_stall = 1'b0;
    end else begin
      if (r_stall) check("r_stable", 64'({RVALID, RID, RDATA, RRESP, RLAST}), 64'({1'b1, r_hold}));
      if (RVALID && RREADY) begin
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL r_unexpected: got RDATA=%h, required no beat", RDATA);
        end else begin
          r_exp_t e;
          e = rq.pop_front();
          check("r_beat", 64'({RID, RDATA, RRESP, RLAST}), 64'({e.id, e.data, e.resp, e.last}));
        end
      end
      r_stall = RVALID && !RREADY;
      r_hold  = {RID, RDATA, RRESP, RLAST};
    end
  end

  // ------------------------------------------------------------------ drivers
  task automatic aw_send(input logic [IdW-1:0] id, input logic [7:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY && n < Timeout) begin @(negedge ACLK); n++; end
    if (!AWREADY) note_timeout("aw_handshake");
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [IdW-1:0] id, input logic [7:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ARREADY && n < Timeout) begin @(negedge ACLK); n++; end
    if (!ARREADY) note_timeout("ar_handshake");
    tick();
    ARVALID = 1'b0;
    check("r_latency", 64'(RVALID), 64'(1));
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    repeat ($urandom_range(0, 2)) tick();
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!WREADY && n < Timeout) begin @(negedge ACLK); n++; end
    if (!WREADY) note_timeout("w_handshake");
    tick();
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic b_take();
    int n;
    repeat ($urandom_range(0, 3)) tick();
    BREADY = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!BVALID && n < Timeout) begin @(negedge ACLK); n++; end
    if (!BVALID) note_timeout("b_handshake");
    tick();
    BREADY = 1'b0;
  endtask

  // Writes wdata/wstrb[0..len]; early >= 0 puts the single WLAST on that beat instead.
  task automatic do_write(input logic [IdW-1:0] id, input logic [7:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int early);
    bit lasts [256];
    bit bad, mis;
    int a;
    bad = burst[1] || (size != 3'd2);
    mis = 1'b0;
    a   = int'(addr[7:2]);
    for (int i = 0; i <= len; i++) begin
      lasts[i] = (early < 0) ? (i == len) : (i == early);
      if (lasts[i] != (i == len)) mis = 1'b1;
      if (!bad) begin
        for (int b = 0; b < 4; b++) if (wstrb[i][b]) model[a][8*b +: 8] = wdata[i][8*b +: 8];
      end
      if (burst == 2'b01) a = (a + 1) % Depth;
    end
    bq.push_back('{id: id, resp: (bad || mis) ? 2'b10 : 2'b00});
    aw_send(id, addr, 8'(len), size, burst);
    for (int i = 0; i <= len; i++) w_send(wdata[i], wstrb[i], lasts[i]);
    b_take();
  endtask

  task automatic do_read(input logic [IdW-1:0] id, input logic [7:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    bit bad;
    int a, n;
    bad = burst[1] || (size != 3'd2);
    a   = int'(addr[7:2]);
    for (int i = 0; i <= len; i++) begin
      rq.push_back('{id: id, data: bad ? 32'h0 : model[a], resp: bad ? 2'b10 : 2'b00,
                     last: (i == len)});
      if (burst == 2'b01) a = (a + 1) % Depth;
    end
    ar_send(id, addr, 8'(len), size, burst);
    RREADY = toggle ? 1'b1 : 1'($urandom_range(0, 1));
    n = 0;
    while (rq.size() != 0 && n < 4000) begin
      tick();
      n++;
      RREADY = toggle ? !RREADY : ($urandom_range(0, 3) != 0);
    end
    if (rq.size() != 0) begin
      note_timeout("r_beats");
      rq.delete();
    end else begin
      check("rvalid_drop", 64'(RVALID), 64'(0));
    end
    RREADY = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST, BRESP, RRESP, BID, RID,
                     RDATA}), 64'(0));
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      wdata[i] = $urandom;
      wstrb[i] = 4'hF;
    end
  endtask

  // ------------------------------------------------------------------ sequence
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    bit bv;
    repeat (2) @(negedge ACLK);
    check_reset_outputs("reset_outputs");
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    check("ready_before_edge", 64'({AWREADY, ARREADY}), 64'(0));
    @(negedge ACLK);
    check("ready_after_reset", 64'({AWREADY, ARREADY, WREADY}), 64'(3'b110));
    tick();

    // Give every word a known value.
    fill_random(64);
    do_write(1'b0, 8'h00, 63, 3'd2, 2'b01, -1);
    do_read(1'b1, 8'h00, 63, 3'd2, 2'b01, 1'b0);

    // 8-beat INCR 1..8
    for (int i = 0; i < 8; i++) begin wdata[i] = 32'(i + 1); wstrb[i] = 4'hF; end
    do_write(1'b1, 8'h00, 7, 3'd2, 2'b01, -1);
    do_read(1'b0, 8'h00, 7, 3'd2, 2'b01, 1'b0);

    // Byte strobes: expect 0xFF34FF78
    wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF;
    do_write(1'b0, 8'h10, 0, 3'd2, 2'b01, -1);
    wdata[0] = 32'h1234_5678; wstrb[0] = 4'b0101;
    do_write(1'b0, 8'h10, 0, 3'd2, 2'b01, -1);
    do_read(1'b1, 8'h10, 0, 3'd2, 2'b01, 1'b0);

    // FIXED write leaves the last beat; INCR wraps 0xFC -> 0x00
    wdata[0] = 32'hA; wdata[1] = 32'hB; wdata[2] = 32'hC; wdata[3] = 32'hD;
    for (int i = 0; i < 4; i++) wstrb[i] = 4'hF;
    do_write(1'b1, 8'h20, 3, 3'd2, 2'b00, -1);
    do_read(1'b1, 8'h20, 0, 3'd2, 2'b01, 1'b0);
    fill_random(4);
    do_write(1'b0, 8'hF8, 3, 3'd2, 2'b01, -1);
    do_read(1'b0, 8'hF8, 3, 3'd2, 2'b01, 1'b0);
    do_read(1'b1, 8'hF8, 3, 3'd2, 2'b00, 1'b0);

    // RREADY toggling every cycle
    do_read(1'b1, 8'h00, 7, 3'd2, 2'b01, 1'b1);

    // Error bursts: WRAP, reserved, bad size, early WLAST
    fill_random(4);
    do_write(1'b1, 8'h30, 3, 3'd2, 2'b10, -1);
    do_read(1'b1, 8'h30, 3, 3'd2, 2'b10, 1'b1);
    do_read(1'b0, 8'h30, 3, 3'd2, 2'b01, 1'b0);
    do_write(1'b0, 8'h30, 3, 3'd2, 2'b11, -1);
    do_write(1'b1, 8'h30, 1, 3'd1, 2'b01, -1);
    do_read(1'b0, 8'h30, 1, 3'd0, 2'b01, 1'b0);
    do_read(1'b0, 8'h30, 3, 3'd2, 2'b01, 1'b0);
    do_write(1'b1, 8'h50, 3, 3'd2, 2'b01, 2);
    do_read(1'b1, 8'h50, 3, 3'd2, 2'b01, 1'b0);

    // Randomized mix
    for (int k = 0; k < 30; k++) begin
      logic [1:0]     burst;
      logic [2:0]     size;
      logic [7:0]     addr;
      logic [IdW-1:0] id;
      int             len, early;
      burst = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      size  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
      addr  = 8'($urandom_range(0, 255));
      id    = IdW'($urandom_range(0, 1));
      len   = int'($urandom_range(0, 15));
      early = (len > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wdata[i] = $urandom;
          wstrb[i] = 4'($urandom_range(0, 15));
        end
        do_write(id, addr, len, size, burst, early);
      end else begin
        do_read(id, addr, len, size, burst, 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the middle of an 8-beat write: three beats land, no B response
    fill_random(8);
    aw_send(1'b1, 8'h40, 8'd7, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      w_send(wdata[i], 4'hF, 1'b0);
      model[16 + i] = wdata[i];
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    check_reset_outputs("abort_reset_outputs");
    tick();
    ARESET = 1'b0;
    BREADY = 1'b1;
    bv = 1'b0;
    repeat (10) begin
      @(negedge ACLK);
      if (BVALID) bv = 1'b1;
    end
    check("no_b_after_abort", 64'(bv), 64'(0));
    check("ready_after_abort", 64'({AWREADY, ARREADY, WREADY}), 64'(3'b110));
    tick();
    BREADY = 1'b0;
    do_read(1'b0, 8'h40, 7, 3'd2, 2'b01, 1'b0);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
